// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the multiply/divide unit, also used by decode and hazard logic.
package muldiv_unit_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NOP6  = 3'd6,
    MD_NOP7  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Iteration registers for shift-add multiply and restoring divide, plus sign fix-up.
// acc/low are shared: for multiply acc is the running upper half and low holds the
// multiplier being shifted out; for divide acc is the partial remainder and low
// shifts the dividend out while the quotient bits shift in.
module muldiv_datapath
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   low;
  logic [WIDTH-1:0]   opb;
  logic               div_mode;
  logic               neg_main;
  logic               neg_rem;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [WIDTH:0]     acc_step;
  logic [WIDTH-1:0]   low_step;
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand magnitudes: two's-complement abs for signed ops (most-negative maps to itself, read unsigned)
  always_comb begin
    a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag = (is_signed && b[WIDTH-1]) ? -b : b;
  end

  // One iteration: add-then-shift for multiply, shift-then-trial-subtract for divide
  always_comb begin
    sum      = acc + (low[0] ? {1'b0, opb} : '0);
    shifted  = {acc[WIDTH-1:0], low[WIDTH-1]};
    diff     = shifted - {1'b0, opb};
    acc_step = {1'b0, sum[WIDTH:1]};
    low_step = {sum[0], low[WIDTH-1:1]};
    if (div_mode) begin
      if (!diff[WIDTH]) begin
        acc_step = diff;
        low_step = {low[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = shifted;
        low_step = {low[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Sign correction of the finished magnitudes and HI/LO result selection
  always_comb begin
    prod_raw = {acc[WIDTH-1:0], low};
    prod_fix = neg_main ? -prod_raw : prod_raw;
    quo_fix  = neg_main ? -low : low;
    rem_fix  = neg_rem ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    res_hi   = div_mode ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = div_mode ? quo_fix : prod_fix[WIDTH-1:0];
  end

  // Working registers: load magnitudes and result signs on accept, iterate while calculating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      low      <= '0;
      opb      <= '0;
      div_mode <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
    end else if (load) begin
      acc      <= '0;
      low      <= a_mag;
      opb      <= b_mag;
      div_mode <= is_div;
      neg_main <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_rem  <= is_signed && a[WIDTH-1];
    end else if (step) begin
      acc      <= acc_step;
      low      <= low_step;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO, with start/busy/done handshake,
// flush abort and divide-by-zero reporting.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  md_state_e        state;
  md_state_e        state_n;
  md_op_e           op_e;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             load;
  logic             step;
  logic             fix_write;
  logic             mt_hi;
  logic             mt_lo;
  logic             div0_n;
  logic             is_div;
  logic             is_signed;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign op_e      = md_op_e'(op);
  assign is_div    = (op_e == MD_DIV) || (op_e == MD_DIVU);
  assign is_signed = (op_e == MD_MULT) || (op_e == MD_DIV);
  assign busy      = (state != ST_IDLE);
  assign step      = (state == ST_CALC);

  muldiv_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk      (CLK),
    .rst_n    (RST),
    .load     (load),
    .step     (step),
    .is_div   (is_div),
    .is_signed(is_signed),
    .a        (rs),
    .b        (rt),
    .res_hi   (res_hi),
    .res_lo   (res_lo)
  );

  // Next-state and control decode; flush wins over both a new start and the FIX write
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    load      = 1'b0;
    fix_write = 1'b0;
    mt_hi     = 1'b0;
    mt_lo     = 1'b0;
    div0_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !flush) begin
          case (op_e)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              if (is_div && (rt == '0)) begin
                div0_n = 1'b1;
              end else begin
                load    = 1'b1;
                cnt_n   = CNT_W'(WIDTH);
                state_n = ST_CALC;
              end
            end
            MD_MTHI: mt_hi = 1'b1;
            MD_MTLO: mt_lo = 1'b1;
            default: ;
          endcase
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_n = ST_FIX;
          end
        end
      end
      ST_FIX: begin
        state_n   = ST_IDLE;
        fix_write = !flush;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, counter and one-cycle status pulses
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      div0  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      done  <= fix_write;
      div0  <= div0_n;
    end
  end

  // HI/LO architectural registers: written by a finished mul/div or by MTHI/MTLO
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hi <= '0;
      lo <= '0;
    end else if (fix_write) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (mt_hi) begin
      hi <= rs;
    end else if (mt_lo) begin
      lo <= rs;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases with literal results plus
// randomized traffic compared every cycle against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] rs = '0;
  logic [W-1:0] rt = '0;
  logic         flush = 1'b0;
  logic         busy;
  logic         done;
  logic         div0;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic [W-1:0] p_hi = '0;
  logic [W-1:0] p_lo = '0;
  logic         m_done = 1'b0;
  logic         m_div0 = 1'b0;
  int           m_left = 0;

  always #5 CLK = ~CLK;

  muldiv_unit #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .start(start),
    .op   (op),
    .rs   (rs),
    .rt   (rt),
    .flush(flush),
    .busy (busy),
    .done (done),
    .div0 (div0),
    .hi   (hi),
    .lo   (lo)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: result lands W+1 edges after acceptance unless flushed
  always @(posedge CLK or negedge RST) begin
    longint sa, sb, q, r;
    logic [63:0] pr;
    if (!RST) begin
      m_hi = '0; m_lo = '0; m_done = 1'b0; m_div0 = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      m_div0 = 1'b0;
      if (m_left > 0) begin
        if (flush) begin
          m_left = 0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
          end
        end
      end else if (start && !flush) begin
        sa = longint'($signed(rs));
        sb = longint'($signed(rt));
        case (op)
          3'd0: begin pr = 64'(sa * sb); p_hi = pr[63:32]; p_lo = pr[31:0]; m_left = W + 1; end
          3'd1: begin pr = {32'b0, rs} * {32'b0, rt}; p_hi = pr[63:32]; p_lo = pr[31:0]; m_left = W + 1; end
          3'd2: begin
            if (rt == '0) m_div0 = 1'b1;
            else begin
              q = sa / sb; r = sa % sb;
              p_lo = W'(q); p_hi = W'(r); m_left = W + 1;
            end
          end
          3'd3: begin
            if (rt == '0) m_div0 = 1'b1;
            else begin p_lo = rs / rt; p_hi = rs % rt; m_left = W + 1; end
          end
          3'd4: m_hi = rs;
          3'd5: m_lo = rs;
          default: ;
        endcase
      end
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge CLK) begin
    if (RST) begin
      checkOutput("cyc busy", {63'b0, busy}, {63'b0, (m_left > 0)});
      checkOutput("cyc done", {63'b0, done}, {63'b0, m_done});
      checkOutput("cyc div0", {63'b0, div0}, {63'b0, m_div0});
      checkOutput("cyc hi", {32'b0, hi}, {32'b0, m_hi});
      checkOutput("cyc lo", {32'b0, lo}, {32'b0, m_lo});
    end
  end

  // Present one request for a single cycle; returns at the negedge after the accepting edge
  task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge CLK);
    start = 1'b1; op = o; rs = a; rt = b;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic runOp(input string name, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    int nbusy = 0;
    int guard = 0;
    applyStimulus(o, a, b);
    while (!done && guard < 200) begin
      if (busy) nbusy++;
      @(negedge CLK);
      guard++;
    end
    checkOutput({name, " done"}, {63'b0, done}, 64'd1);
    checkOutput({name, " busy_cycles"}, 64'(nbusy), 64'(W + 1));
    checkOutput({name, " busy_in_done"}, {63'b0, busy}, 64'd0);
    checkOutput({name, " hi"}, {32'b0, hi}, {32'b0, eh});
    checkOutput({name, " lo"}, {32'b0, lo}, {32'b0, el});
    @(negedge CLK);
    checkOutput({name, " done_pulse"}, {63'b0, done}, 64'd0);
  endtask

  function automatic logic [W-1:0] randOperand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 20));
      4: return -W'($urandom_range(1, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int guard;
    int seen_done;

    // Asynchronous reset at start-up
    #1 RST = 1'b0;
    #1;
    checkOutput("reset hi", {32'b0, hi}, 64'd0);
    checkOutput("reset lo", {32'b0, lo}, 64'd0);
    checkOutput("reset busy", {63'b0, busy}, 64'd0);
    checkOutput("reset done", {63'b0, done}, 64'd0);
    checkOutput("reset div0", {63'b0, div0}, 64'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    runOp("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    runOp("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
    runOp("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    runOp("divu", 3'd3, 32'd7, 32'd2, 32'd1, 32'd3);
    runOp("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    // Divide by zero: one-cycle div0, nothing else moves
    applyStimulus(3'd3, 32'd55, 32'd0);
    checkOutput("div0 pulse", {63'b0, div0}, 64'd1);
    checkOutput("div0 busy", {63'b0, busy}, 64'd0);
    checkOutput("div0 done", {63'b0, done}, 64'd0);
    checkOutput("div0 hi", {32'b0, hi}, 64'd0);
    checkOutput("div0 lo", {32'b0, lo}, 64'h8000_0000);
    @(negedge CLK);
    checkOutput("div0 once", {63'b0, div0}, 64'd0);
    checkOutput("div0 stay_idle", {63'b0, busy}, 64'd0);

    // MTHI writes directly
    applyStimulus(3'd4, 32'h1234_5678, 32'd0);
    checkOutput("mthi hi", {32'b0, hi}, 64'h1234_5678);
    checkOutput("mthi lo", {32'b0, lo}, 64'h8000_0000);
    checkOutput("mthi busy", {63'b0, busy}, 64'd0);
    checkOutput("mthi done", {63'b0, done}, 64'd0);

    // Start during busy is ignored
    applyStimulus(3'd0, 32'd6, 32'd7);
    repeat (3) @(negedge CLK);
    start = 1'b1; op = 3'd0; rs = 32'd100; rt = 32'd100;
    repeat (5) @(negedge CLK);
    start = 1'b0;
    guard = 0;
    while (!done && guard < 200) begin @(negedge CLK); guard++; end
    checkOutput("ignored done", {63'b0, done}, 64'd1);
    checkOutput("ignored hi", {32'b0, hi}, 64'd0);
    checkOutput("ignored lo", {32'b0, lo}, 64'd42);
    @(negedge CLK);
    checkOutput("ignored no_second", {63'b0, busy}, 64'd0);

    // Flush in CALC cycle 10
    applyStimulus(3'd0, 32'd5, 32'd5);
    repeat (9) @(negedge CLK);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    checkOutput("flush busy", {63'b0, busy}, 64'd0);
    checkOutput("flush done", {63'b0, done}, 64'd0);
    checkOutput("flush hi", {32'b0, hi}, 64'd0);
    checkOutput("flush lo", {32'b0, lo}, 64'd42);
    seen_done = 0;
    repeat (40) begin @(negedge CLK); if (done) seen_done++; end
    checkOutput("flush no_done", 64'(seen_done), 64'd0);
    runOp("after_flush", 3'd1, 32'd3, 32'd4, 32'd0, 32'd12);

    // Reset mid-CALC
    applyStimulus(3'd3, 32'd1000, 32'd3);
    repeat (5) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    checkOutput("midreset hi", {32'b0, hi}, 64'd0);
    checkOutput("midreset lo", {32'b0, lo}, 64'd0);
    checkOutput("midreset busy", {63'b0, busy}, 64'd0);
    @(negedge CLK);
    RST = 1'b1;
    runOp("post_reset_divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);

    // Randomized traffic, checked every cycle by the compare process
    repeat (3000) begin
      @(negedge CLK);
      start = ($urandom_range(0, 2) == 0);
      op    = 3'($urandom_range(0, 7));
      rs    = randOperand();
      rt    = ($urandom_range(0, 9) == 0) ? '0 : randOperand();
      flush = ($urandom_range(0, 60) == 0);
    end
    @(negedge CLK);
    start = 1'b0;
    flush = 1'b0;
    guard = 0;
    while (busy && guard < 100) begin @(negedge CLK); guard++; end
    checkOutput("final idle", {63'b0, busy}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
